rv32i_multicycle_control: RTL and testbench

Main control FSM for the multicycle RV32I core. It sequences the shared ALU, the unified instruction/data memory port, the PC/PC_old registers, the IR and the register file through fetch, decode, execute, memory and writeback steps. It decodes the latched instruction's op/funct3/funct7 and drives every datapath select and write enable. It sits inside rv32i_multicycle_core next to the datapath registers and muxes.

---
 rtl/rv32i_multicycle_control.sv | 257 +++++++++++++++++++++++++
 tb/tb_rv32i_multicycle_control.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_control.sv
// Main control FSM for the multicycle RV32I core.
// It sequences fetch, decode, execute, memory and writeback, and drives every
// datapath select and write enable from the current state and the latched
// instruction fields.
// Optional feature: define RV32I_CTRL_PERF_COUNTERS_EN to add the
// cycle_count/instret_count outputs.
module rv32i_multicycle_control #(
  parameter int unsigned ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  alu_zero,
  input  logic                  alu_lsb,
  output logic                  pc_ena,
  output logic                  pc_src,
  output logic                  ir_write,
  output logic                  mem_src,
  output logic                  mem_wr_ena,
  output logic                  reg_write,
  output logic [1:0]            alu_a_src,
  output logic [1:0]            alu_b_src,
  output logic [1:0]            result_src,
  output logic [2:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  halted
`ifdef RV32I_CTRL_PERF_COUNTERS_EN
  ,
  output logic [31:0]           cycle_count,
  output logic [31:0]           instret_count
`endif
);

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD  = ALU_CTRL_W'(0),
    ALU_SUB  = ALU_CTRL_W'(1),
    ALU_SLT  = ALU_CTRL_W'(2),
    ALU_SLTU = ALU_CTRL_W'(3),
    ALU_AND  = ALU_CTRL_W'(4),
    ALU_OR   = ALU_CTRL_W'(5),
    ALU_XOR  = ALU_CTRL_W'(6),
    ALU_SLL  = ALU_CTRL_W'(7),
    ALU_SRL  = ALU_CTRL_W'(8),
    ALU_SRA  = ALU_CTRL_W'(9)
  } alu_control_t;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I,
    ALU_WB, BRANCH, JAL, JALR, LUI, AUIPC, ERROR
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] A_PC = 2'd0, A_PC_OLD = 2'd1, A_RS1 = 2'd2, A_ZERO = 2'd3;
  localparam logic [1:0] B_FOUR = 2'd0, B_IMM = 2'd1, B_RS2 = 2'd2;
  localparam logic [1:0] R_ALU_OLD = 2'd0, R_ALU = 2'd1, R_MEM = 2'd2;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;

  state_t       state_q, state_d;
  alu_control_t alu_op;
  logic         pc_upd, ir_ld, mem_we, rf_we;
  logic         br_cond, br_illegal;
  logic         we_ok;

  // ALU operation for register/immediate arithmetic from funct3
  function automatic alu_control_t f3_alu(input logic [2:0] f3, input logic sub_en,
                                          input logic sra_en);
    case (f3)
      3'b000:  f3_alu = sub_en ? ALU_SUB : ALU_ADD;
      3'b001:  f3_alu = ALU_SLL;
      3'b010:  f3_alu = ALU_SLT;
      3'b011:  f3_alu = ALU_SLTU;
      3'b100:  f3_alu = ALU_XOR;
      3'b101:  f3_alu = sra_en ? ALU_SRA : ALU_SRL;
      3'b110:  f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  endfunction

  // State register; reset wins over the advance enable
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Next-state, datapath selects and write enables
  always_comb begin
    state_d    = state_q;
    pc_upd     = 1'b0;
    ir_ld      = 1'b0;
    mem_we     = 1'b0;
    rf_we      = 1'b0;
    pc_src     = 1'b0;
    mem_src    = 1'b0;
    alu_a_src  = A_PC;
    alu_b_src  = B_FOUR;
    result_src = R_ALU_OLD;
    imm_src    = IMM_I;
    alu_op     = ALU_ADD;
    br_cond    = 1'b0;
    br_illegal = 1'b0;

    case (state_q)
      FETCH: begin
        ir_ld      = 1'b1;
        result_src = R_ALU;
        pc_upd     = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        alu_a_src = A_PC_OLD;
        alu_b_src = B_IMM;
        imm_src   = (op == OP_BRANCH) ? IMM_B : ((op == OP_JAL) ? IMM_J : IMM_I);
        case (op)
          OP_LOAD, OP_STORE: state_d = MEM_ADR;
          OP_R:              state_d = EXEC_R;
          OP_I:              state_d = EXEC_I;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
          OP_LUI:            state_d = LUI;
          OP_AUIPC:          state_d = AUIPC;
          default:           state_d = ERROR;
        endcase
      end
      MEM_ADR: begin
        alu_a_src = A_RS1;
        alu_b_src = B_IMM;
        imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (op == OP_STORE) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_src = 1'b1;
        state_d = MEM_WB;
      end
      MEM_WB: begin
        result_src = R_MEM;
        rf_we      = 1'b1;
        state_d    = FETCH;
      end
      MEM_WRITE: begin
        mem_src = 1'b1;
        mem_we  = 1'b1;
        state_d = FETCH;
      end
      EXEC_R: begin
        alu_a_src = A_RS1;
        alu_b_src = B_RS2;
        alu_op    = f3_alu(funct3, funct7b5, funct7b5);
        state_d   = ALU_WB;
      end
      EXEC_I: begin
        alu_a_src = A_RS1;
        alu_b_src = B_IMM;
        alu_op    = f3_alu(funct3, 1'b0, funct7b5);
        state_d   = ALU_WB;
      end
      ALU_WB: begin
        result_src = R_ALU_OLD;
        rf_we      = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_a_src = A_RS1;
        alu_b_src = B_RS2;
        pc_src    = 1'b1;
        case (funct3[2:1])
          2'b00: begin alu_op = ALU_SUB;  br_cond = alu_zero; end
          2'b10: begin alu_op = ALU_SLT;  br_cond = alu_lsb;  end
          2'b11: begin alu_op = ALU_SLTU; br_cond = alu_lsb;  end
          default: br_illegal = 1'b1;
        endcase
        pc_upd  = ~br_illegal & (br_cond ^ funct3[0]);
        state_d = br_illegal ? ERROR : FETCH;
      end
      JAL: begin
        alu_a_src = A_PC_OLD;
        alu_b_src = B_FOUR;
        pc_src    = 1'b1;
        pc_upd    = 1'b1;
        state_d   = ALU_WB;
      end
      JALR: begin
        alu_a_src = A_RS1;
        alu_b_src = B_IMM;
        state_d   = JAL;
      end
      LUI: begin
        alu_a_src = A_ZERO;
        alu_b_src = B_IMM;
        imm_src   = IMM_U;
        state_d   = ALU_WB;
      end
      AUIPC: begin
        alu_a_src = A_PC_OLD;
        alu_b_src = B_IMM;
        imm_src   = IMM_U;
        state_d   = ALU_WB;
      end
      default: state_d = ERROR;
    endcase

    // Write enables are suppressed while stalled or while reset is asserted
    we_ok       = ena & rst;
    pc_ena      = pc_upd & we_ok;
    ir_write    = ir_ld & we_ok;
    mem_wr_ena  = mem_we & we_ok;
    reg_write   = rf_we & we_ok;
    alu_control = alu_op;
    halted      = (state_q == ERROR);
  end

`ifdef RV32I_CTRL_PERF_COUNTERS_EN
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] instret_count_q, instret_count_d;
  logic        last_step;

  // Counter increments: enabled non-halted cycles and retiring states
  always_comb begin
    last_step       = (state_q == MEM_WB) || (state_q == MEM_WRITE) ||
                      (state_q == ALU_WB) || (state_q == BRANCH);
    cycle_count_d   = cycle_count_q;
    instret_count_d = instret_count_q;
    if (ena && (state_q != ERROR)) cycle_count_d = cycle_count_q + 32'd1;
    if (ena && last_step)          instret_count_d = instret_count_q + 32'd1;
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_count_q   <= 32'd0;
      instret_count_q <= 32'd0;
    end else begin
      cycle_count_q   <= cycle_count_d;
      instret_count_q <= instret_count_d;
    end
  end

  assign cycle_count   = cycle_count_q;
  assign instret_count = instret_count_q;
`endif

endmodule

// File: tb/tb_rv32i_multicycle_control.sv
// Directed bench for rv32i_multicycle_control: each cycle's expected output
// signature (with don't-care mask) is queued and compared at the falling edge.
module tb_rv32i_multicycle_control;

  localparam int X = -1;
  localparam int ADD = 0, SUB = 1, SLT = 2, SLTU = 3, AND = 4, OR = 5, XOR = 6,
                 SLL = 7, SRL = 8, SRA = 9;

  typedef struct {
    logic [19:0] val;
    logic [19:0] mask;
    string       tag;
  } exp_t;

  logic        clk, rst, ena;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, alu_zero, alu_lsb;
  logic        pc_ena, pc_src, ir_write, mem_src, mem_wr_ena, reg_write, halted;
  logic [1:0]  alu_a_src, alu_b_src, result_src;
  logic [2:0]  imm_src;
  logic [3:0]  alu_control;
  logic [19:0] obs;
`ifdef RV32I_CTRL_PERF_COUNTERS_EN
  logic [31:0] cycle_count, instret_count;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  rv32i_multicycle_control #(.ALU_CTRL_W(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .alu_zero(alu_zero), .alu_lsb(alu_lsb),
    .pc_ena(pc_ena), .pc_src(pc_src), .ir_write(ir_write), .mem_src(mem_src),
    .mem_wr_ena(mem_wr_ena), .reg_write(reg_write), .alu_a_src(alu_a_src),
    .alu_b_src(alu_b_src), .result_src(result_src), .imm_src(imm_src),
    .alu_control(alu_control), .halted(halted)
`ifdef RV32I_CTRL_PERF_COUNTERS_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );

  assign obs = {pc_ena, pc_src, ir_write, mem_src, mem_wr_ena, reg_write,
                alu_a_src, alu_b_src, result_src, imm_src, alu_control, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void put(inout exp_t r, input int lsb, input int w, input int v);
    for (int i = 0; i < w; i++) begin
      r.mask[lsb+i] = (v >= 0);
      r.val[lsb+i]  = (v >= 0) ? v[i] : 1'b0;
    end
  endfunction

  // Expected signature; any field given as X is not compared
  function automatic exp_t e(input int pe, input int ps, input int irw, input int ms,
                             input int mw, input int rw, input int a, input int b,
                             input int rs, input int imm, input int alu, input int h);
    exp_t r;
    r.val = '0; r.mask = '0; r.tag = "";
    put(r, 19, 1, pe);  put(r, 18, 1, ps);  put(r, 17, 1, irw);
    put(r, 16, 1, ms);  put(r, 15, 1, mw);  put(r, 14, 1, rw);
    put(r, 12, 2, a);   put(r, 10, 2, b);   put(r, 8, 2, rs);
    put(r, 5, 3, imm);  put(r, 1, 4, alu);  put(r, 0, 1, h);
    return r;
  endfunction

  // Queue the expectation, compare at the falling edge, then advance one clock
  task automatic cyc(input string tag, input exp_t x);
    exp_t y;
    x.tag = tag;
    sb.push_back(x);
    @(negedge clk);
    y = sb.pop_front();
    checks++;
    assert (((obs ^ y.val) & y.mask) === 20'd0)
      else begin
        failures++;
        $error("FAIL %s observed=%05h expected=%05h mask=%05h", y.tag, obs, y.val, y.mask);
      end
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  exp_t F, WB, JJ, ER, EI;

  initial begin
    F  = e(1, 0, 1, 0, 0, 0, 0, 0, 1, X, ADD, 0);
    WB = e(0, X, 0, X, 0, 1, X, X, 0, X, X, 0);
    JJ = e(1, 1, 0, X, 0, 0, 1, 0, X, X, ADD, 0);
    ER = e(0, X, 0, X, 0, 0, X, X, X, X, X, 1);

    rst = 1'b0; ena = 1'b1; alu_zero = 1'b0; alu_lsb = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    cyc("reset_gated", e(0, X, 0, X, 0, 0, 0, 0, 1, X, ADD, 0));
    rst = 1'b1;

    // R-type SUB
    cyc("sub_fetch", F);
    cyc("sub_decode", e(0, X, 0, X, 0, 0, 1, 1, X, 0, ADD, 0));
    cyc("sub_exec", e(0, X, 0, X, 0, 0, 2, 2, X, X, SUB, 0));
    cyc("sub_wb", WB);

    // R-type SRA
    set_instr(7'b0110011, 3'b101, 1'b1);
    cyc("sra_fetch", F);
    cyc("sra_decode", e(0, X, 0, X, 0, 0, 1, 1, X, 0, ADD, 0));
    cyc("sra_exec", e(0, X, 0, X, 0, 0, 2, 2, X, X, SRA, 0));
    cyc("sra_wb", WB);

    // Load
    set_instr(7'b0000011, 3'b010, 1'b0);
    cyc("ld_fetch", F);
    cyc("ld_decode", e(0, X, 0, X, 0, 0, 1, 1, X, 0, ADD, 0));
    cyc("ld_adr", e(0, X, 0, X, 0, 0, 2, 1, X, 0, ADD, 0));
    cyc("ld_read", e(0, X, 0, 1, 0, 0, X, X, X, X, X, 0));
    cyc("ld_wb", e(0, X, 0, X, 0, 1, X, X, 2, X, X, 0));

    // Store
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("st_fetch", F);
    cyc("st_decode", e(0, X, 0, X, 0, 0, 1, 1, X, 0, ADD, 0));
    cyc("st_adr", e(0, X, 0, X, 0, 0, 2, 1, X, 1, ADD, 0));
    cyc("st_write", e(0, X, 0, 1, 1, 0, X, X, X, X, X, 0));

    // BNE not equal -> taken, then equal -> not taken
    set_instr(7'b1100011, 3'b001, 1'b0); alu_zero = 1'b0;
    cyc("bne_fetch", F);
    cyc("bne_decode", e(0, X, 0, X, 0, 0, 1, 1, X, 2, ADD, 0));
    cyc("bne_taken", e(1, 1, 0, X, 0, 0, 2, 2, X, X, SUB, 0));
    alu_zero = 1'b1;
    cyc("bne2_fetch", F);
    cyc("bne2_decode", e(0, X, 0, X, 0, 0, 1, 1, X, 2, ADD, 0));
    cyc("bne_not_taken", e(0, 1, 0, X, 0, 0, 2, 2, X, X, SUB, 0));

    // BLTU with lsb=1 -> taken; BGE with lsb=1 -> not taken
    set_instr(7'b1100011, 3'b110, 1'b0); alu_lsb = 1'b1; alu_zero = 1'b0;
    cyc("bltu_fetch", F);
    cyc("bltu_decode", e(0, X, 0, X, 0, 0, 1, 1, X, 2, ADD, 0));
    cyc("bltu_taken", e(1, 1, 0, X, 0, 0, 2, 2, X, X, SLTU, 0));
    set_instr(7'b1100011, 3'b101, 1'b0);
    cyc("bge_fetch", F);
    cyc("bge_decode", e(0, X, 0, X, 0, 0, 1, 1, X, 2, ADD, 0));
    cyc("bge_not_taken", e(0, 1, 0, X, 0, 0, 2, 2, X, X, SLT, 0));
    alu_lsb = 1'b0;

    // JALR -> JAL -> ALU_WB
    set_instr(7'b1100111, 3'b000, 1'b0);
    cyc("jalr_fetch", F);
    cyc("jalr_decode", e(0, X, 0, X, 0, 0, 1, 1, X, 0, ADD, 0));
    cyc("jalr_target", e(0, X, 0, X, 0, 0, 2, 1, X, 0, ADD, 0));
    cyc("jalr_jal", JJ);
    cyc("jalr_wb", WB);

    // JAL
    set_instr(7'b1101111, 3'b000, 1'b0);
    cyc("jal_fetch", F);
    cyc("jal_decode", e(0, X, 0, X, 0, 0, 1, 1, X, 4, ADD, 0));
    cyc("jal_jump", JJ);
    cyc("jal_wb", WB);

    // LUI and AUIPC
    set_instr(7'b0110111, 3'b000, 1'b0);
    cyc("lui_fetch", F);
    cyc("lui_decode", e(0, X, 0, X, 0, 0, 1, 1, X, 0, ADD, 0));
    cyc("lui_exec", e(0, X, 0, X, 0, 0, 3, 1, X, 3, ADD, 0));
    cyc("lui_wb", WB);
    set_instr(7'b0010111, 3'b000, 1'b0);
    cyc("auipc_fetch", F);
    cyc("auipc_decode", e(0, X, 0, X, 0, 0, 1, 1, X, 0, ADD, 0));
    cyc("auipc_exec", e(0, X, 0, X, 0, 0, 1, 1, X, 3, ADD, 0));
    cyc("auipc_wb", WB);

    // ADDI with funct7b5=1 stays ADD
    set_instr(7'b0010011, 3'b000, 1'b1);
    cyc("addi_fetch", F);
    cyc("addi_decode", e(0, X, 0, X, 0, 0, 1, 1, X, 0, ADD, 0));
    cyc("addi_exec", e(0, X, 0, X, 0, 0, 2, 1, X, 0, ADD, 0));
    cyc("addi_wb", WB);

    // SRAI with stalls in FETCH, EXEC_I and ALU_WB
    set_instr(7'b0010011, 3'b101, 1'b1);
    EI = e(0, X, 0, X, 0, 0, 2, 1, X, 0, SRA, 0);
    ena = 1'b0;
    cyc("stall_fetch", e(0, 0, 0, 0, 0, 0, 0, 0, 1, X, ADD, 0));
    ena = 1'b1;
    cyc("srai_fetch", F);
    cyc("srai_decode", e(0, X, 0, X, 0, 0, 1, 1, X, 0, ADD, 0));
    ena = 1'b0;
    for (int i = 0; i < 3; i++) cyc("stall_exec_i", EI);
    ena = 1'b1;
    cyc("srai_exec", EI);
    ena = 1'b0;
    cyc("stall_wb", e(0, X, 0, X, 0, 0, X, X, 0, X, X, 0));
    ena = 1'b1;
    cyc("srai_wb", WB);

    // Illegal branch funct3 -> ERROR, cleared by reset
    set_instr(7'b1100011, 3'b010, 1'b0);
    cyc("bill_fetch", F);
    cyc("bill_decode", e(0, X, 0, X, 0, 0, 1, 1, X, 2, ADD, 0));
    cyc("bill_branch", e(0, X, 0, X, 0, 0, 2, 2, X, X, X, 0));
    cyc("bill_error", ER);
    rst = 1'b0;
    cyc("bill_reset", e(0, X, 0, X, 0, 0, X, X, X, X, X, X));
    rst = 1'b1;
    cyc("bill_refetch", F);

    // Illegal opcode: ERROR held, then reset
    set_instr(7'b1111111, 3'b000, 1'b0);
    cyc("ill_decode", e(0, X, 0, X, 0, 0, 1, 1, X, 0, ADD, 0));
    for (int i = 0; i < 10; i++) cyc("ill_error_hold", ER);
    rst = 1'b0;
    cyc("ill_reset", e(0, X, 0, X, 0, 0, X, X, X, X, X, X));
    rst = 1'b1;
    cyc("ill_refetch", F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
